write_back_stage: RTL and testbench

- Parametrised MEM/WB pipeline register plus write-back source select for the pipelined RISC-V core.
- Latches up to NUM_SRC candidate results (ALU, load data, PC+4, immediate, …) with destination info, selects one, and drives the register-file write port one cycle later.
- Adds stall/flush handling, x0 write suppression and a retired-instruction counter.

---
 rtl/write_back_stage.sv | 99 +++++++++
 tb/tb_write_back_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register with write-back source select, x0 write suppression
// and retired-instruction counter. Optional load align/extend: WB_LOAD_EXTEND_EN.
module write_back_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SEL_W      = $clog2(NUM_SRC),
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    validIn,
    input  logic [NUM_SRC*XLEN-1:0] srcData,
    input  logic [SEL_W-1:0]        srcSel,
    input  logic                    regWriteIn,
    input  logic [REG_ADDR_W-1:0]   rdIn,
    input  logic [1:0]              loadSize,
    input  logic                    loadUnsigned,
    input  logic [1:0]              addrLow,
    output logic                    validOut,
    output logic                    regWriteOut,
    output logic [REG_ADDR_W-1:0]   rdOut,
    output logic [XLEN-1:0]         dataBack,
    output logic [CNT_W-1:0]        retireCount
);

    logic                  r_valid;
    logic                  r_regwr;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_data;
    logic [CNT_W-1:0]      r_cnt;

    logic [XLEN-1:0]       w_sel_data;
    logic [XLEN-1:0]       w_wb_data;

    // Out-of-range selects fall through to source 0 (ALU).
    always_comb begin
        w_sel_data = srcData[XLEN-1:0];
        for (int unsigned k = 1; k < NUM_SRC; k++) begin
            if (srcSel == SEL_W'(k)) begin
                w_sel_data = srcData[k*XLEN +: XLEN];
            end
        end
    end

`ifdef WB_LOAD_EXTEND_EN
    logic [XLEN-1:0] w_mem;
    logic [XLEN-1:0] w_byte_sh;
    logic [XLEN-1:0] w_half_sh;
    logic [XLEN-1:0] w_ext;

    // Misaligned halves use addrLow[1] only; loadSize 11 behaves as word.
    always_comb begin
        w_mem     = srcData[XLEN +: XLEN];
        w_byte_sh = w_mem >> {addrLow, 3'b000};
        w_half_sh = w_mem >> {addrLow[1], 4'b0000};
        case (loadSize)
            2'b00:   w_ext = {{(XLEN-8){~loadUnsigned & w_byte_sh[7]}}, w_byte_sh[7:0]};
            2'b01:   w_ext = {{(XLEN-16){~loadUnsigned & w_half_sh[15]}}, w_half_sh[15:0]};
            default: w_ext = w_mem;
        endcase
        w_wb_data = (srcSel == SEL_W'(1)) ? w_ext : w_sel_data;
    end
`else
    logic w_unused_load;
    assign w_unused_load = ^{loadSize, loadUnsigned, addrLow};
    assign w_wb_data     = w_sel_data;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_valid <= 1'b0;
            r_regwr <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else if (!stall) begin
            if (flush || !validIn) begin
                r_valid <= 1'b0;
                r_regwr <= 1'b0;
            end else begin
                r_valid <= 1'b1;
                r_regwr <= regWriteIn && (rdIn != '0);
                r_rd    <= rdIn;
                r_data  <= w_wb_data;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign validOut    = r_valid;
    assign regWriteOut = r_regwr;
    assign rdOut       = r_rd;
    assign dataBack    = r_data;
    assign retireCount = r_cnt;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: default instance plus a NUM_SRC=3,
// CNT_W=4 instance sharing the same stimulus.
module tb_write_back_stage;

    logic         clk = 1'b0;
    logic         rstN;
    logic         stall, flush, validIn, regWriteIn, loadUnsigned;
    logic [127:0] srcData;
    logic [1:0]   srcSel, loadSize, addrLow;
    logic [4:0]   rdIn;

    logic         validOut, regWriteOut;
    logic [4:0]   rdOut;
    logic [31:0]  dataBack, retireCount;

    logic         validOut_s, regWriteOut_s;
    logic [4:0]   rdOut_s;
    logic [31:0]  dataBack_s;
    logic [3:0]   retireCount_s;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    write_back_stage u_dut (
        .clk(clk), .rstN(rstN), .stall(stall), .flush(flush), .validIn(validIn),
        .srcData(srcData), .srcSel(srcSel), .regWriteIn(regWriteIn), .rdIn(rdIn),
        .loadSize(loadSize), .loadUnsigned(loadUnsigned), .addrLow(addrLow),
        .validOut(validOut), .regWriteOut(regWriteOut), .rdOut(rdOut),
        .dataBack(dataBack), .retireCount(retireCount)
    );

    write_back_stage #(.NUM_SRC(3), .CNT_W(4)) u_small (
        .clk(clk), .rstN(rstN), .stall(stall), .flush(flush), .validIn(validIn),
        .srcData(srcData[95:0]), .srcSel(srcSel), .regWriteIn(regWriteIn), .rdIn(rdIn),
        .loadSize(loadSize), .loadUnsigned(loadUnsigned), .addrLow(addrLow),
        .validOut(validOut_s), .regWriteOut(regWriteOut_s), .rdOut(rdOut_s),
        .dataBack(dataBack_s), .retireCount(retireCount_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; stall = 0; flush = 0; validIn = 0; regWriteIn = 0;
        srcData = '0; srcSel = 0; rdIn = 0; loadSize = 2'b10; loadUnsigned = 0; addrLow = 0;
        step();
        tot_cnt++;
        if ({validOut, regWriteOut, rdOut, dataBack, retireCount} !== 71'd0)
            $display("FAIL reset_main got v=%b w=%b rd=%0d d=%h c=%0d exp all 0",
                     validOut, regWriteOut, rdOut, dataBack, retireCount);
        else pass_cnt++;
        tot_cnt++;
        if ({validOut_s, regWriteOut_s, rdOut_s, dataBack_s, retireCount_s} !== 43'd0)
            $display("FAIL reset_small got v=%b w=%b rd=%0d d=%h c=%0d exp all 0",
                     validOut_s, regWriteOut_s, rdOut_s, dataBack_s, retireCount_s);
        else pass_cnt++;
        @(negedge clk);
        rstN = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        validIn = 1; srcSel = 0; rdIn = 5; regWriteIn = 1;
        srcData = {32'h3333_3333, 32'h0000_0104, 32'h80FF_7F01, 32'h1234_5678};
        step(); exp_cnt++;
        tot_cnt++;
        if (dataBack !== 32'h1234_5678) $display("FAIL basic_data got=%h exp=12345678", dataBack);
        else pass_cnt++;
        tot_cnt++;
        if ({validOut, regWriteOut, rdOut} !== {1'b1, 1'b1, 5'd5})
            $display("FAIL basic_ctl got v=%b w=%b rd=%0d exp v=1 w=1 rd=5", validOut, regWriteOut, rdOut);
        else pass_cnt++;
        tot_cnt++;
        if (retireCount !== 32'(exp_cnt)) $display("FAIL basic_cnt got=%0d exp=%0d", retireCount, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_x0();
        rdIn = 0; regWriteIn = 1; srcData[31:0] = 32'hAAAA_0000;
        step(); exp_cnt++;
        tot_cnt++;
        if ({validOut, regWriteOut, rdOut, dataBack} !== {1'b1, 1'b0, 5'd0, 32'hAAAA_0000})
            $display("FAIL x0_write got v=%b w=%b rd=%0d d=%h exp v=1 w=0 rd=0 d=aaaa0000",
                     validOut, regWriteOut, rdOut, dataBack);
        else pass_cnt++;
        tot_cnt++;
        if (retireCount !== 32'(exp_cnt)) $display("FAIL x0_cnt got=%0d exp=%0d", retireCount, exp_cnt);
        else pass_cnt++;
        regWriteIn = 0; rdIn = 6;
        step(); exp_cnt++;
        tot_cnt++;
        if ({validOut, regWriteOut, rdOut} !== {1'b1, 1'b0, 5'd6})
            $display("FAIL nowrite got v=%b w=%b rd=%0d exp v=1 w=0 rd=6", validOut, regWriteOut, rdOut);
        else pass_cnt++;
    endtask

    task automatic test_stall_flush();
        srcSel = 2; rdIn = 7; regWriteIn = 1;
        step(); exp_cnt++;
        tot_cnt++;
        if (dataBack !== 32'h0000_0104) $display("FAIL sel_pc4 got=%h exp=00000104", dataBack);
        else pass_cnt++;
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            srcSel = 0; srcData[31:0] = 32'hDEAD_0000 + 32'(i); rdIn = 5'(9 + i);
            validIn = 1; flush = (i == 3);
            step();
            tot_cnt++;
            if ({validOut, regWriteOut, rdOut, dataBack} !== {1'b1, 1'b1, 5'd7, 32'h0000_0104} ||
                retireCount !== 32'(exp_cnt))
                $display("FAIL stall_hold[%0d] got v=%b w=%b rd=%0d d=%h c=%0d exp v=1 w=1 rd=7 d=00000104 c=%0d",
                         i, validOut, regWriteOut, rdOut, dataBack, retireCount, exp_cnt);
            else pass_cnt++;
        end
        stall = 0; flush = 1;
        step();
        tot_cnt++;
        if ({validOut, regWriteOut, rdOut, dataBack} !== {1'b0, 1'b0, 5'd7, 32'h0000_0104} ||
            retireCount !== 32'(exp_cnt))
            $display("FAIL flush_bubble got v=%b w=%b rd=%0d d=%h c=%0d exp v=0 w=0 rd=7 d=00000104 c=%0d",
                     validOut, regWriteOut, rdOut, dataBack, retireCount, exp_cnt);
        else pass_cnt++;
        flush = 0; validIn = 0; rdIn = 12;
        step();
        tot_cnt++;
        if ({validOut, regWriteOut, rdOut} !== {1'b0, 1'b0, 5'd7} || retireCount !== 32'(exp_cnt))
            $display("FAIL invalid_bubble got v=%b w=%b rd=%0d c=%0d exp v=0 w=0 rd=7 c=%0d",
                     validOut, regWriteOut, rdOut, retireCount, exp_cnt);
        else pass_cnt++;
        validIn = 1;
    endtask

    task automatic test_select();
        srcData = {32'h3333_3333, 32'h0000_0104, 32'h80FF_7F01, 32'h1234_5678};
        srcSel = 3; rdIn = 4;
        step(); exp_cnt++;
        tot_cnt++;
        if (dataBack !== 32'h3333_3333) $display("FAIL sel3_main got=%h exp=33333333", dataBack);
        else pass_cnt++;
        tot_cnt++;
        if (dataBack_s !== 32'h1234_5678) $display("FAIL sel3_oob_small got=%h exp=12345678", dataBack_s);
        else pass_cnt++;
`ifndef WB_LOAD_EXTEND_EN
        srcSel = 1; loadSize = 2'b00; addrLow = 2; loadUnsigned = 0;
        step(); exp_cnt++;
        tot_cnt++;
        if (dataBack !== 32'h80FF_7F01) $display("FAIL sel1_raw got=%h exp=80ff7f01", dataBack);
        else pass_cnt++;
`endif
    endtask

`ifdef WB_LOAD_EXTEND_EN
    task automatic test_load_extend();
        logic [1:0]  sz [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        logic        un [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  al [7] = '{2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
        logic [31:0] ex [7] = '{32'hFFFF_FFFF, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                                32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_0001};
        srcData[63:32] = 32'h80FF_7F01; srcSel = 1;
        for (int i = 0; i < 7; i++) begin
            loadSize = sz[i]; loadUnsigned = un[i]; addrLow = al[i];
            step(); exp_cnt++;
            tot_cnt++;
            if (dataBack !== ex[i]) $display("FAIL load_ext[%0d] got=%h exp=%h", i, dataBack, ex[i]);
            else pass_cnt++;
        end
        loadSize = 2'b10; addrLow = 0; loadUnsigned = 0;
    endtask
`endif

    task automatic test_wrap();
        srcSel = 0; srcData[31:0] = 32'hCAFE_0001; rdIn = 3; regWriteIn = 1; validIn = 1;
        stall = 0; flush = 0;
        @(posedge clk); #3 rstN = 0; #2 rstN = 1;
        for (int i = 0; i < 15; i++) step();
        tot_cnt++;
        if (retireCount_s !== 4'd15 || retireCount !== 32'd15)
            $display("FAIL wrap_pre got small=%0d main=%0d exp small=15 main=15", retireCount_s, retireCount);
        else pass_cnt++;
        #2 rstN = 0;
        #1;
        tot_cnt++;
        if ({validOut, regWriteOut, rdOut, dataBack, retireCount} !== 71'd0 ||
            {validOut_s, regWriteOut_s, rdOut_s, dataBack_s, retireCount_s} !== 43'd0)
            $display("FAIL async_reset got v=%b d=%h c=%0d small v=%b c=%0d exp all 0",
                     validOut, dataBack, retireCount, validOut_s, retireCount_s);
        else pass_cnt++;
        #1 rstN = 1;
        for (int i = 0; i < 17; i++) step();
        tot_cnt++;
        if (retireCount_s !== 4'd1) $display("FAIL wrap_small got=%0d exp=1", retireCount_s);
        else pass_cnt++;
        tot_cnt++;
        if (retireCount !== 32'd17 || dataBack_s !== 32'hCAFE_0001)
            $display("FAIL wrap_main got c=%0d d_small=%h exp c=17 d_small=cafe0001", retireCount, dataBack_s);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_stall_flush();
        test_select();
`ifdef WB_LOAD_EXTEND_EN
        test_load_extend();
`endif
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
